// File: rtl/hazard_ctrl_if.sv
// Decode-stage hazard query bundle: D-stage operand/producer info in,
// stall and forwarding selects out.
interface hazard_ctrl_if;
   logic [4:0] A1_D;
   logic [4:0] A2_D;
   logic [4:0] A3_D;
   logic [2:0] Tuse1_D;
   logic [2:0] Tuse2_D;
   logic [2:0] Tnew_D;
   logic       md_start_D;
   logic       md_div_D;
   logic       md_use_D;
   logic       stall;
   logic [1:0] fwd_rs_D;
   logic [1:0] fwd_rt_D;
   logic [1:0] fwd_rs_E;
   logic [1:0] fwd_rt_E;
   logic       fwd_rt_M;
   logic       md_busy;

   modport master (
      output A1_D, A2_D, A3_D, Tuse1_D, Tuse2_D, Tnew_D,
      output md_start_D, md_div_D, md_use_D,
      input  stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy
   );

   modport slave (
      input  A1_D, A2_D, A3_D, Tuse1_D, Tuse2_D, Tnew_D,
      input  md_start_D, md_div_D, md_use_D,
      output stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: tracks E/M/W producers and the HI/LO busy counter,
// producing stall and bypass selects with no added latency.
module hazard_ctrl (
   input  logic          clk,
   input  logic          reset,
   hazard_ctrl_if.slave  hif
);

   localparam logic [3:0] MD_DIV_CYC  = 4'd10;
   localparam logic [3:0] MD_MULT_CYC = 4'd5;

   logic [4:0] e_a1_q, e_a1_d, e_a2_q, e_a2_d, e_a3_q, e_a3_d;
   logic [2:0] e_t_q, e_t_d;
   logic [4:0] m_a2_q, m_a2_d, m_a3_q, m_a3_d;
   logic [2:0] m_t_q, m_t_d;
   logic [4:0] w_a3_q, w_a3_d;
   logic [3:0] md_cnt_q, md_cnt_d;

   function automatic logic [2:0] sat_dec(input logic [2:0] t);
      return (t == 3'd0) ? 3'd0 : t - 3'd1;
   endfunction

   // A zero source register can never match, which also keeps A3=0 producers inert.
   function automatic logic src_stall(input logic [4:0] a, input logic [2:0] tuse,
                                      input logic [4:0] ea3, input logic [2:0] et,
                                      input logic [4:0] ma3, input logic [2:0] mt);
      return (a != '0) && (((a == ea3) && (et > tuse)) || ((a == ma3) && (mt > tuse)));
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [4:0] a,
                                          input logic [4:0] n_a3, input logic n_rdy,
                                          input logic [4:0] f_a3, input logic f_rdy);
      if ((a != '0) && (a == n_a3) && n_rdy) return 2'd1;
      if ((a != '0) && (a == f_a3) && f_rdy) return 2'd2;
      return 2'd0;
   endfunction

   always_comb begin
      hif.md_busy  = (md_cnt_q != '0);
      hif.stall    = src_stall(hif.A1_D, hif.Tuse1_D, e_a3_q, e_t_q, m_a3_q, m_t_q)
                   | src_stall(hif.A2_D, hif.Tuse2_D, e_a3_q, e_t_q, m_a3_q, m_t_q)
                   | (hif.md_use_D & hif.md_busy);
      hif.fwd_rs_D = fwd_sel(hif.A1_D, e_a3_q, e_t_q == '0, m_a3_q, m_t_q == '0);
      hif.fwd_rt_D = fwd_sel(hif.A2_D, e_a3_q, e_t_q == '0, m_a3_q, m_t_q == '0);
      hif.fwd_rs_E = fwd_sel(e_a1_q, m_a3_q, m_t_q == '0, w_a3_q, 1'b1);
      hif.fwd_rt_E = fwd_sel(e_a2_q, m_a3_q, m_t_q == '0, w_a3_q, 1'b1);
      hif.fwd_rt_M = (m_a2_q != '0) && (m_a2_q == w_a3_q);
   end

   always_comb begin
      e_a1_d   = '0;
      e_a2_d   = '0;
      e_a3_d   = '0;
      e_t_d    = '0;
      m_a2_d   = '0;
      m_a3_d   = '0;
      m_t_d    = '0;
      w_a3_d   = '0;
      md_cnt_d = '0;
      if (reset) begin
         if (!hif.stall) begin
            e_a1_d = hif.A1_D;
            e_a2_d = hif.A2_D;
            e_a3_d = hif.A3_D;
            e_t_d  = sat_dec(hif.Tnew_D);
         end
         m_a2_d = e_a2_q;
         m_a3_d = e_a3_q;
         m_t_d  = sat_dec(e_t_q);
         w_a3_d = m_a3_q;
         // A start only takes effect when the instruction actually leaves D.
         if (!hif.stall && hif.md_start_D)
            md_cnt_d = hif.md_div_D ? MD_DIV_CYC : MD_MULT_CYC;
         else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      e_a1_q   <= e_a1_d;
      e_a2_q   <= e_a2_d;
      e_a3_q   <= e_a3_d;
      e_t_q    <= e_t_d;
      m_a2_q   <= m_a2_d;
      m_a3_q   <= m_a3_d;
      m_t_q    <= m_t_d;
      w_a3_q   <= w_a3_d;
      md_cnt_q <= md_cnt_d;
   end

endmodule
